// File: rtl/lcd_ctrl_if.sv
// Byte-write channel from the LCD IO register into the LCD pin driver.
// Latency: none, plain wires grouped for port hygiene.
// Backpressure: wr_rdy from the slave; the master holds vld/rs/data until accepted.
interface lcd_ctrl_if;
    logic       wr_vld;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_rdy;

    modport master (output wr_vld, output wr_rs, output wr_data, input wr_rdy);
    modport slave  (input wr_vld, input wr_rs, input wr_data, output wr_rdy);
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780-style character LCD pin driver: power-up init, then one command/data byte per handshake.
// Latency: pins update the cycle after accept; occupancy T_SETUP+T_EN+T_HOLD+(T_CMD or T_CLR) cycles.
// Backpressure: wr_rdy only in IDLE after init; requests while busy are ignored, not queued.
module lcd_ctrl #(
    parameter int T_SETUP = 2,
    parameter int T_EN    = 25,
    parameter int T_HOLD  = 2,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000,
    parameter int T_PWRUP = 750000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    lcd_ctrl_if.slave   wr,
    input  logic        i_lcd_on,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_init_done
);

    localparam int CMAX = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [2:0] ST_PWRUP = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_IDLE  = 3'd5;

    localparam logic [CW-1:0] LD_PWRUP = CW'(T_PWRUP - 1);
    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_EN    = CW'(T_EN - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_CMD   = CW'(T_CMD - 1);
    localparam logic [CW-1:0] LD_CLR   = CW'(T_CLR - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          init_done_q, init_done_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;
    logic          en_q, en_d;
    logic          lcd_on_q, lcd_on_d;
    logic          cnt_zero;
    logic          is_clr;
    logic          accept;

    // Init ROM: 8-bit/2-line function set, display on, clear, entry mode increment.
    function automatic logic [7:0] init_byte(input logic [1:0] i);
        case (i)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    endfunction

    assign cnt_zero = (cnt_q == '0);
    // Clear and return-home need the long execution wait.
    assign is_clr   = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
    assign wr.wr_rdy = (state_q == ST_IDLE) && init_done_q;
    assign accept   = wr.wr_vld && wr.wr_rdy;

    // Next-state logic: every phase loads N-1 and moves on when the counter hits 0.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        data_d      = data_q;
        rs_d        = rs_q;
        en_d        = en_q;
        lcd_on_d    = i_lcd_on;
        case (state_q)
            ST_PWRUP: begin
                if (cnt_zero) begin
                    state_d = ST_SETUP;
                    data_d  = init_byte(2'd0);
                    rs_d    = 1'b0;
                    idx_d   = 2'd0;
                    cnt_d   = LD_SETUP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_d = ST_PULSE;
                    en_d    = 1'b1;
                    cnt_d   = LD_EN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_zero) begin
                    state_d = ST_HOLD;
                    en_d    = 1'b0;
                    cnt_d   = LD_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d = ST_WAIT;
                    cnt_d   = is_clr ? LD_CLR : LD_CMD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_zero) begin
                    if (init_done_q) begin
                        state_d = ST_IDLE;
                    end else if (idx_q == 2'd3) begin
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        data_d  = init_byte(idx_q + 2'd1);
                        rs_d    = 1'b0;
                        state_d = ST_SETUP;
                        cnt_d   = LD_SETUP;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                    data_d  = wr.wr_data;
                    rs_d    = wr.wr_rs;
                    cnt_d   = LD_SETUP;
                end
            end
            default: begin
                state_d = ST_PWRUP;
                cnt_d   = LD_PWRUP;
                en_d    = 1'b0;
            end
        endcase
    end

    // State registers; reset drops EN immediately and restarts the power-up phase.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_PWRUP;
            cnt_q       <= LD_PWRUP;
            idx_q       <= 2'd0;
            init_done_q <= 1'b0;
            data_q      <= 8'h00;
            rs_q        <= 1'b0;
            en_q        <= 1'b0;
            lcd_on_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            en_q        <= en_d;
            lcd_on_q    <= lcd_on_d;
        end
    end

    assign o_lcd_data  = data_q;
    assign o_lcd_rs    = rs_q;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_en    = en_q;
    assign o_lcd_on    = lcd_on_q;
    assign o_init_done = init_done_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_lcd_ctrl;

    localparam int T_SETUP = 1;
    localparam int T_EN    = 2;
    localparam int T_HOLD  = 1;
    localparam int T_CMD   = 5;
    localparam int T_CLR   = 20;
    localparam int T_PWRUP = 30;
    localparam int OCC_CMD = T_SETUP + T_EN + T_HOLD + T_CMD;   // 9
    localparam int OCC_CLR = T_SETUP + T_EN + T_HOLD + T_CLR;   // 24

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lcd_on_in;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_on_out, init_done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    lcd_ctrl_if wr ();

    lcd_ctrl #(
        .T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD),
        .T_CMD(T_CMD), .T_CLR(T_CLR), .T_PWRUP(T_PWRUP)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .wr          (wr),
        .i_lcd_on    (lcd_on_in),
        .o_lcd_data  (lcd_data),
        .o_lcd_rs    (lcd_rs),
        .o_lcd_rw    (lcd_rw),
        .o_lcd_en    (lcd_en),
        .o_lcd_on    (lcd_on_out),
        .o_init_done (init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_en(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            tick();
            if (lcd_en === 1'b1) at = cyc;
        end
    endtask

    task automatic pulse_len(input int budget, output int n);
        n = 0;
        while (lcd_en === 1'b1 && n < budget) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_rdy(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            tick();
            if (wr.wr_rdy === 1'b1) at = cyc;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"},   32'(lcd_en), 0);
        check({tag, "_data"}, 32'(lcd_data), 0);
        check({tag, "_rs"},   32'(lcd_rs), 0);
        check({tag, "_rdy"},  32'(wr.wr_rdy), 0);
        check({tag, "_done"}, 32'(init_done), 0);
        check({tag, "_on"},   32'(lcd_on_out), 0);
    endtask

    // One transfer starting with wr_rdy visible; hold_vld keeps vld high with junk data while busy.
    task automatic xfer(input string tag, input logic rs, input logic [7:0] d,
                        input int exp_occ, input logic hold_vld);
        int a, at, n;
        wr.wr_vld  = 1'b1;
        wr.wr_rs   = rs;
        wr.wr_data = d;
        tick();
        a = cyc;
        check({tag, "_rdy_drop"}, 32'(wr.wr_rdy), 0);
        check({tag, "_pin_data"}, 32'(lcd_data), 32'(d));
        check({tag, "_pin_rs"},   32'(lcd_rs), 32'(rs));
        wr.wr_vld  = hold_vld;
        wr.wr_rs   = ~rs;
        wr.wr_data = ~d;
        wait_en(10, at);
        check({tag, "_en_delay"}, 32'(at - a), 32'(T_SETUP));
        pulse_len(10, n);
        check({tag, "_en_width"}, 32'(n), 32'(T_EN));
        wait_rdy(100, at);
        check({tag, "_occupancy"}, 32'(at - a), 32'(exp_occ));
        check({tag, "_held_data"}, 32'(lcd_data), 32'(d));
        check({tag, "_held_rs"},   32'(lcd_rs), 32'(rs));
    endtask

    // Checks the four init pulses from the reset edge (cyc = 0) through init_done.
    task automatic check_init(input string tag);
        logic [7:0] rom [4];
        int         rise [4];
        int         at, n;
        rom[0] = 8'h38; rom[1] = 8'h0C; rom[2] = 8'h01; rom[3] = 8'h06;
        // PWRUP 30 cycles, SETUP 1, so EN first high 31 cycles after the reset edge;
        // then 9 cycles per normal command, 24 after the clear.
        rise[0] = 31; rise[1] = 40; rise[2] = 49; rise[3] = 73;
        for (int i = 0; i < 4; i++) begin
            wait_en(60, at);
            check($sformatf("%s_rise%0d", tag, i), 32'(at), 32'(rise[i]));
            check($sformatf("%s_data%0d", tag, i), 32'(lcd_data), 32'(rom[i]));
            check($sformatf("%s_rs%0d", tag, i), 32'(lcd_rs), 0);
            check($sformatf("%s_rdy%0d", tag, i), 32'(wr.wr_rdy), 0);
            pulse_len(10, n);
            check($sformatf("%s_width%0d", tag, i), 32'(n), 32'(T_EN));
        end
        wait_rdy(40, at);
        check({tag, "_rdy_at"}, 32'(at), 81);
        check({tag, "_done"}, 32'(init_done), 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        lcd_on_in  = 1'b0;
        wr.wr_vld  = 1'b0;
        wr.wr_rs   = 1'b0;
        wr.wr_data = 8'h00;

        // Reset state
        tick(); tick(); tick();
        check_all_zero("reset");
        check("reset_rw", 32'(lcd_rw), 0);

        // Release; the last reset edge is cycle 0
        rst_n = 1'b1;
        cyc   = 0;

        // i_lcd_on follows one cycle later while init runs
        tick(); tick(); tick();
        lcd_on_in = 1'b1;
        check("lcd_on_before", 32'(lcd_on_out), 0);
        tick();
        check("lcd_on_rise", 32'(lcd_on_out), 1);
        lcd_on_in = 1'b0;
        tick();
        check("lcd_on_fall", 32'(lcd_on_out), 0);
        lcd_on_in = 1'b1;
        check("pwrup_en_low", 32'(lcd_en), 0);

        // Init sequence timing and content
        check_init("init");
        check("rw_const", 32'(lcd_rw), 0);
        check("lcd_on_held", 32'(lcd_on_out), 1);

        // Single data byte, then clear-class command vs data with the same value
        xfer("data41", 1'b1, 8'h41, OCC_CMD, 1'b0);
        xfer("cmd01",  1'b0, 8'h01, OCC_CLR, 1'b0);
        xfer("dat01",  1'b1, 8'h01, OCC_CMD, 1'b0);
        xfer("cmd03",  1'b0, 8'h03, OCC_CLR, 1'b0);
        xfer("cmd04",  1'b0, 8'h04, OCC_CMD, 1'b0);
        xfer("cmd00",  1'b0, 8'h00, OCC_CMD, 1'b0);

        // vld held high throughout with junk while busy
        xfer("hold0", 1'b1, 8'h10, OCC_CMD, 1'b1);
        xfer("hold1", 1'b0, 8'h02, OCC_CLR, 1'b1);
        xfer("hold2", 1'b1, 8'h7E, OCC_CMD, 1'b1);
        wr.wr_vld = 1'b0;
        tick();
        check("idle_no_accept", 32'(wr.wr_rdy), 1);

        // Reset during PULSE of a data byte
        wr.wr_vld  = 1'b1;
        wr.wr_rs   = 1'b1;
        wr.wr_data = 8'h55;
        tick();
        wr.wr_vld = 1'b0;
        tick();
        check("mid_pulse_en", 32'(lcd_en), 1);
        rst_n = 1'b0;
        tick();
        check_all_zero("midreset");
        rst_n = 1'b1;
        cyc   = 0;
        check_init("replay");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
